// File: rtl/pwm_meas_pkg.sv
// Shared types and default sizing for the PWM duty/period meter.
package pwm_meas_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        MEAS_HI = 2'd1,
        MEAS_LO = 2'd2
    } meas_state_e;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Control inputs and measurement results of the PWM duty meter.
interface pwm_duty_meter_if
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck;
    logic             stuck_level;

    modport master (
        output enable,
        output pwm_in,
        input  high_time,
        input  period,
        input  valid,
        input  stuck,
        input  stuck_level
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output high_time,
        output period,
        output valid,
        output stuck,
        output stuck_level
    );

endinterface

// File: rtl/pwm_edge_detect.sv
// Two-flop sampler of the PWM line with registered-level rise/fall decode.
module pwm_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic pwm_i,
    output logic pwm_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic pwm_q;
    logic pwm_qq;

    // Sampling continues regardless of the meter's enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q  <= 1'b0;
            pwm_qq <= 1'b0;
        end else begin
            pwm_q  <= pwm_i;
            pwm_qq <= pwm_q;
        end
    end

    assign pwm_q_o = pwm_q;
    assign rise_o  = pwm_q & ~pwm_qq;
    assign fall_o  = ~pwm_q & pwm_qq;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of each PWM cycle and flags a stuck line.
module pwm_duty_meter
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clock,
    input  logic            reset,
    pwm_duty_meter_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

    logic pwm_q;
    logic rise;
    logic fall;

    meas_state_e      state_q;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] high_time_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             stuck_q;
    logic             stuck_level_q;

    pwm_edge_detect u_edge (
        .clock   (clock),
        .reset   (reset),
        .pwm_i   (bus.pwm_in),
        .pwm_q_o (pwm_q),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SYNC;
            hi_cnt_q      <= '0;
            per_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            high_time_q   <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else if (!bus.enable) begin
            state_q    <= SYNC;
            hi_cnt_q   <= '0;
            per_cnt_q  <= '0;
            idle_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (rise) begin
                        state_q    <= MEAS_HI;
                        hi_cnt_q   <= ONE;
                        per_cnt_q  <= ONE;
                        idle_cnt_q <= '0;
                        stuck_q    <= 1'b0;
                    end else if (!stuck_q) begin
                        // Idle watchdog only arms while no stuck condition is latched.
                        if (idle_cnt_q == TO_M1) begin
                            stuck_q       <= 1'b1;
                            stuck_level_q <= pwm_q;
                            idle_cnt_q    <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + ONE;
                        end
                    end
                end
                MEAS_HI, MEAS_LO: begin
                    if (per_cnt_q == TO_V && !rise) begin
                        stuck_q       <= 1'b1;
                        stuck_level_q <= pwm_q;
                        state_q       <= SYNC;
                        hi_cnt_q      <= '0;
                        per_cnt_q     <= '0;
                        idle_cnt_q    <= '0;
                    end else if (state_q == MEAS_HI) begin
                        per_cnt_q <= per_cnt_q + ONE;
                        if (fall) begin
                            state_q <= MEAS_LO;
                        end else begin
                            hi_cnt_q <= hi_cnt_q + ONE;
                        end
                    end else if (rise) begin
                        high_time_q <= hi_cnt_q;
                        period_q    <= per_cnt_q;
                        valid_q     <= 1'b1;
                        stuck_q     <= 1'b0;
                        hi_cnt_q    <= ONE;
                        per_cnt_q   <= ONE;
                        state_q     <= MEAS_HI;
                    end else begin
                        per_cnt_q <= per_cnt_q + ONE;
                    end
                end
                default: begin
                    state_q   <= SYNC;
                    hi_cnt_q  <= '0;
                    per_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.high_time   = high_time_q;
    assign bus.period      = period_q;
    assign bus.valid       = valid_q;
    assign bus.stuck       = stuck_q;
    assign bus.stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomised and directed bench for pwm_duty_meter against a timestamp-based reference.
module tb_pwm_duty_meter;
    import pwm_meas_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 255;

    logic clock;
    logic reset;

    pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

    pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;

    // Reference: timestamps of the last rise/fall on the sampled line.
    int n = 0;
    int rise_t = 0;
    int fall_t = 0;
    int sync_t = 0;
    bit m_meas = 0;
    bit m_fall = 0;
    bit prev1 = 0;
    bit prev2 = 0;
    int exp_hi = 0;
    int exp_per = 0;
    bit exp_vld = 0;
    bit exp_stk = 0;
    bit exp_lvl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    task automatic model_edge(input bit p, input bit e, input bit r);
        bit q, qq, rise, fall;
        n++;
        q    = prev1;
        qq   = prev2;
        rise = q & ~qq;
        fall = ~q & qq;
        exp_vld = 1'b0;
        if (r) begin
            prev1   = 1'b0;
            prev2   = 1'b0;
            exp_hi  = 0;
            exp_per = 0;
            exp_stk = 1'b0;
            exp_lvl = 1'b0;
            m_meas  = 1'b0;
            sync_t  = n;
            return;
        end
        prev2 = prev1;
        prev1 = p;
        if (!e) begin
            m_meas = 1'b0;
            sync_t = n;
        end else if (m_meas) begin
            if ((n - rise_t) == TIMEOUT && !rise) begin
                exp_stk = 1'b1;
                exp_lvl = q;
                m_meas  = 1'b0;
                sync_t  = n;
            end else if (rise) begin
                if (m_fall) begin
                    exp_hi  = fall_t - rise_t;
                    exp_per = n - rise_t;
                    exp_vld = 1'b1;
                end
                exp_stk = 1'b0;
                rise_t  = n;
                m_fall  = 1'b0;
            end else if (fall) begin
                fall_t = n;
                m_fall = 1'b1;
            end
        end else if (rise) begin
            m_meas  = 1'b1;
            rise_t  = n;
            m_fall  = 1'b0;
            exp_stk = 1'b0;
        end else if (!exp_stk && (n - sync_t) == TIMEOUT) begin
            exp_stk = 1'b1;
            exp_lvl = q;
        end
    endtask

    task automatic cyc(input bit p, input bit e, input bit r);
        bus.pwm_in = p;
        bus.enable = e;
        reset      = r;
        @(posedge clock);
        model_edge(p, e, r);
        #1;
        chk("high_time", 32'(bus.high_time), exp_hi);
        chk("period", 32'(bus.period), exp_per);
        chk("valid", 32'(bus.valid), 32'(exp_vld));
        chk("stuck", 32'(bus.stuck), 32'(exp_stk));
        chk("stuck_level", 32'(bus.stuck_level), 32'(exp_lvl));
        if (bus.valid === 1'b1) vld_cnt++;
    endtask

    task automatic run(input bit p, input int len, input bit e);
        for (int i = 0; i < len; i++) cyc(p, e, 1'b0);
    endtask

    task automatic pattern(input int hi, input int lo, input int reps);
        for (int k = 0; k < reps; k++) begin
            run(1'b1, hi, 1'b1);
            run(1'b0, lo, 1'b1);
        end
    endtask

    int v0;
    logic [4:0] gen_cnt;

    initial begin
        bus.pwm_in = 1'b0;
        bus.enable = 1'b0;
        reset      = 1'b1;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        chk("reset_high_time", 32'(bus.high_time), 0);
        chk("reset_stuck", 32'(bus.stuck), 0);

        // 4 high / 12 low, three times
        v0 = vld_cnt;
        pattern(4, 12, 3);
        chk("p4_12_valids", vld_cnt - v0, 2);
        chk("p4_12_high", 32'(bus.high_time), 4);
        chk("p4_12_period", 32'(bus.period), 16);
        chk("p4_12_stuck", 32'(bus.stuck), 0);

        // 5-bit PWM generator, duty 11
        v0 = vld_cnt;
        gen_cnt = '0;
        for (int i = 0; i < 128; i++) begin
            cyc(gen_cnt < 5'd11, 1'b1, 1'b0);
            gen_cnt = gen_cnt + 5'd1;
        end
        chk("gen_valids", vld_cnt - v0, 4);
        chk("gen_high", 32'(bus.high_time), 11);
        chk("gen_period", 32'(bus.period), 32);

        // two good periods, then held high until the timeout
        pattern(4, 12, 2);
        run(1'b1, 270, 1'b1);
        chk("hold_hi_stuck", 32'(bus.stuck), 1);
        chk("hold_hi_level", 32'(bus.stuck_level), 1);
        chk("hold_hi_high", 32'(bus.high_time), 4);
        chk("hold_hi_period", 32'(bus.period), 16);
        run(1'b0, 3, 1'b1);
        pattern(3, 5, 3);
        chk("recover_stuck", 32'(bus.stuck), 0);
        chk("recover_high", 32'(bus.high_time), 3);
        chk("recover_period", 32'(bus.period), 8);

        // enable dropped for 5 cycles during the high phase
        v0 = vld_cnt;
        run(1'b1, 2, 1'b1);
        run(1'b1, 2, 1'b0);
        run(1'b0, 3, 1'b0);
        run(1'b0, 7, 1'b1);
        pattern(4, 12, 3);
        chk("endrop_valids", vld_cnt - v0, 3);
        chk("endrop_high", 32'(bus.high_time), 4);
        chk("endrop_period", 32'(bus.period), 16);

        // synchronous reset during the low phase
        v0 = vld_cnt;
        run(1'b1, 4, 1'b1);
        run(1'b0, 8, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("midrst_high", 32'(bus.high_time), 0);
        chk("midrst_period", 32'(bus.period), 0);
        chk("midrst_valid", 32'(bus.valid), 0);
        run(1'b0, 4, 1'b1);
        pattern(4, 12, 1);
        chk("midrst_valids", vld_cnt - v0, 1);

        // alternating 1/1
        v0 = vld_cnt;
        pattern(1, 1, 20);
        chk("alt_valids", vld_cnt - v0, 20);
        chk("alt_high", 32'(bus.high_time), 1);
        chk("alt_period", 32'(bus.period), 2);

        // held low: timeout from the low phase, then idle watchdog after reset
        run(1'b0, 270, 1'b1);
        chk("hold_lo_stuck", 32'(bus.stuck), 1);
        chk("hold_lo_level", 32'(bus.stuck_level), 0);
        chk("hold_lo_period", 32'(bus.period), 2);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        run(1'b0, 254, 1'b1);
        chk("idle_not_yet", 32'(bus.stuck), 0);
        run(1'b0, 6, 1'b1);
        chk("idle_stuck", 32'(bus.stuck), 1);

        // randomised segments
        for (int s = 0; s < 250; s++) begin
            int hl, ll;
            if ($urandom_range(0, 19) == 0) begin
                hl = $urandom_range(250, 300);
                ll = $urandom_range(1, 10);
            end else begin
                hl = $urandom_range(1, 12);
                ll = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 1) == 1) begin
                int t = hl; hl = ll; ll = t;
            end
            for (int i = 0; i < hl + ll; i++) begin
                cyc(i < hl, $urandom_range(0, 99) != 0, $urandom_range(0, 999) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
